tomasulo_rs: RTL and testbench

Reservation station for one functional-unit class (arith, logic or mpy) in the Tomasulo pipeline. Sits between dispatch and the execution unit. Accepts `dispatch_t` entries whose operands are either values or producer tags. Snoops the CDB to capture outstanding operands, and issues the oldest entry with both operands resolved as an `issue_t` to the execution unit over a valid/ack handshake.

---
 rtl/tomasulo_rs_if.sv | 80 ++++++++
 rtl/tomasulo_rs.sv | 149 ++++++++++++++
 tb/tb_tomasulo_rs.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_rs_if.sv
// Types and port bundle for the Tomasulo reservation station.
//   tomasulo_rs_pkg : dispatch_t (112b), cdb_t (48b), issue_t (110b) and the
//                     operand word/tag union they are built from.
//   tomasulo_rs_if  : dispatch_vld/dispatch/dispatch_rdy (dispatch side),
//                     cdb (broadcast snoop), issue_vld/issue/issue_ack
//                     (execution side), occupancy (status).
//                     slave = the station, master = whoever drives it.
package tomasulo_rs_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int ROB_W = 5;
  localparam int WA_W  = 5;
  localparam int OP_W  = 4;

  // The tag sits in the low bits of the word so a busy operand's u.w reads
  // back as a zero-extended tag.
  typedef struct packed {
    logic [XLEN-TAG_W-1:0] rsvd;
    logic [TAG_W-1:0]      tag;
  } opr_tag_t;

  typedef union packed {
    logic [XLEN-1:0] w;
    opr_tag_t        t;
  } opr_u_t;

  typedef struct packed {
    logic   busy;
    opr_u_t u;
  } oprand_t;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [TAG_W-1:0] tag;
    oprand_t [1:0]    oprand;
    logic [ROB_W-1:0] robid;
    logic [XLEN-1:0]  imm;
  } dispatch_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [WA_W-1:0]  wa;
    logic [XLEN-1:0]  wdata;
    logic [ROB_W-1:0] robid;
  } cdb_t;

  typedef struct packed {
    logic [1:0][XLEN-1:0] rdata;
    logic [OP_W-1:0]      op;
    logic [TAG_W-1:0]     tag;
    logic [XLEN-1:0]      imm;
    logic [ROB_W-1:0]     robid;
  } issue_t;
endpackage

interface tomasulo_rs_if #(
  parameter int RS_N = 4
);
  import tomasulo_rs_pkg::*;

  logic                        dispatch_vld;
  dispatch_t                   dispatch;
  logic                        dispatch_rdy;
  cdb_t                        cdb;
  logic                        issue_vld;
  issue_t                      issue;
  logic                        issue_ack;
  logic [$clog2(RS_N+1)-1:0]   occupancy;

  modport slave (
    input  dispatch_vld, dispatch, cdb, issue_ack,
    output dispatch_rdy, issue_vld, issue, occupancy
  );

  modport master (
    output dispatch_vld, dispatch, cdb, issue_ack,
    input  dispatch_rdy, issue_vld, issue, occupancy
  );
endinterface

// File: rtl/tomasulo_rs.sv
// Reservation station for one functional-unit class.
// Holds up to RS_N dispatched entries, captures outstanding operands from the
// CDB, and moves the oldest entry with both operands resolved into a 1-deep
// output register that drives the execution unit over issue_vld/issue_ack.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   rs   - tomasulo_rs_if.slave: dispatch, cdb snoop, issue, occupancy
module tomasulo_rs
  import tomasulo_rs_pkg::*;
#(
  parameter int RS_N = 4
) (
  input  logic         clk,
  input  logic         rst,
  tomasulo_rs_if.slave rs
);
  localparam int IDX_W = (RS_N > 1) ? $clog2(RS_N) : 1;
  localparam int OCC_W = $clog2(RS_N + 1);

  dispatch_t                    ent_q [RS_N];
  logic [RS_N-1:0]              valid_q;
  // age_q[j][i] = 1 : entry j was allocated before entry i
  logic [RS_N-1:0][RS_N-1:0]    age_q;
  logic [OCC_W-1:0]             occ_q;
  logic                         issue_vld_q;
  issue_t                       issue_q;

  logic [RS_N-1:0]              ready;
  logic [RS_N-1:0]              sel;
  logic                         sel_any;
  logic [IDX_W-1:0]             sel_idx;
  logic [IDX_W-1:0]             alloc_idx;
  logic                         disp_rdy;
  logic                         acc;
  logic                         take;
  dispatch_t                    new_ent;

  // cdb.wa / cdb.robid belong to the register file and ROB, not to us
  logic unused_cdb;
  assign unused_cdb = ^{rs.cdb.wa, rs.cdb.robid};

  function automatic oprand_t snoop(oprand_t o, cdb_t c);
    oprand_t r;
    r = o;
    if (c.vld && o.busy && (o.u.t.tag == c.tag)) begin
      r.busy = 1'b0;
      r.u.w  = c.wdata;
    end
    return r;
  endfunction

  function automatic issue_t to_issue(dispatch_t d);
    issue_t r;
    r.rdata[0] = d.oprand[0].u.w;
    r.rdata[1] = d.oprand[1].u.w;
    r.op       = d.opcode;
    r.tag      = d.tag;
    r.imm      = d.imm;
    r.robid    = d.robid;
    return r;
  endfunction

  // Per-entry ready and oldest-ready select. Readiness looks only at
  // registered operand state, so a capture shows up a cycle later.
  for (genvar g = 0; g < RS_N; g++) begin : g_ent
    logic [RS_N-1:0] older;
    always_comb begin
      older = '0;
      for (int j = 0; j < RS_N; j++) older[j] = age_q[j][g];
    end
    assign ready[g] = valid_q[g] & ~ent_q[g].oprand[0].busy & ~ent_q[g].oprand[1].busy;
    assign sel[g]   = ready[g] & ~|(older & ready);
  end

  // sel is one-hot or zero, so the encode order does not matter
  always_comb begin
    sel_any = |sel;
    sel_idx = '0;
    for (int i = 0; i < RS_N; i++)
      if (sel[i]) sel_idx = IDX_W'(i);
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_N - 1; i >= 0; i--)
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
  end

  // Same-cycle broadcast is folded into the incoming entry so it is not lost
  always_comb begin
    new_ent           = rs.dispatch;
    new_ent.oprand[0] = snoop(rs.dispatch.oprand[0], rs.cdb);
    new_ent.oprand[1] = snoop(rs.dispatch.oprand[1], rs.cdb);
  end

  // Registered occupancy only: a slot freed this cycle is not reusable yet
  assign disp_rdy = ~rst & (occ_q != OCC_W'(RS_N));
  assign acc      = rs.dispatch_vld & disp_rdy;
  assign take     = sel_any & (~issue_vld_q | rs.issue_ack);

  // Entry payload: no reset needed, valid_q qualifies it
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_N; i++) begin
      if (acc && (alloc_idx == IDX_W'(i))) begin
        ent_q[i] <= new_ent;
      end else begin
        ent_q[i].oprand[0] <= snoop(ent_q[i].oprand[0], rs.cdb);
        ent_q[i].oprand[1] <= snoop(ent_q[i].oprand[1], rs.cdb);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      age_q       <= '0;
      occ_q       <= '0;
      issue_vld_q <= 1'b0;
      issue_q     <= '0;
    end else begin
      for (int i = 0; i < RS_N; i++) begin
        if (acc && (alloc_idx == IDX_W'(i)))      valid_q[i] <= 1'b1;
        else if (take && (sel_idx == IDX_W'(i)))  valid_q[i] <= 1'b0;
      end
      // New entry is older than nothing and younger than every valid entry
      if (acc) begin
        for (int j = 0; j < RS_N; j++) begin
          for (int k = 0; k < RS_N; k++) begin
            if (IDX_W'(j) == alloc_idx)      age_q[j][k] <= 1'b0;
            else if (IDX_W'(k) == alloc_idx) age_q[j][k] <= valid_q[j];
          end
        end
      end
      occ_q <= occ_q + OCC_W'(acc) - OCC_W'(take);
      if (take) begin
        issue_vld_q <= 1'b1;
        issue_q     <= to_issue(ent_q[sel_idx]);
      end else if (rs.issue_ack) begin
        issue_vld_q <= 1'b0;
      end
    end
  end

  assign rs.dispatch_rdy = disp_rdy;
  assign rs.issue_vld    = issue_vld_q;
  assign rs.issue        = issue_q;
  assign rs.occupancy    = occ_q;
endmodule

// File: tb/tb_tomasulo_rs.sv
// Testbench for tomasulo_rs: directed scenarios followed by random traffic,
// all checked against an in-order queue model of the station feeding a
// scoreboard that a separate monitor drains.
module tb_tomasulo_rs;
  import tomasulo_rs_pkg::*;

  localparam int RS_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tomasulo_rs_if #(.RS_N(RS_N)) bus();
  tomasulo_rs #(.RS_N(RS_N)) dut (.clk(clk), .rst(rst), .rs(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries kept in dispatch order: the oldest ready one is simply the first
  // ready one in the queue.
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  tag;
    logic [4:0]  robid;
    logic [31:0] imm;
    bit          busy [2];
    logic [31:0] v    [2];
  } m_ent_t;

  m_ent_t mq[$];
  issue_t exp_q[$];
  bit     m_vld = 1'b0;
  bit     m_rst = 1'b0;

  function automatic issue_t mk_iss(m_ent_t e);
    issue_t r;
    r.rdata[0] = e.v[0];
    r.rdata[1] = e.v[1];
    r.op       = e.op;
    r.tag      = e.tag;
    r.imm      = e.imm;
    r.robid    = e.robid;
    return r;
  endfunction

  function automatic bit hit(bit busy, logic [31:0] v);
    return bus.cdb.vld && busy && (v[4:0] == bus.cdb.tag);
  endfunction

  always @(posedge clk) begin : model
    int     k;
    bit     can;
    m_ent_t e;
    m_rst = rst;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_vld = 1'b0;
    end else begin
      can = (mq.size() < RS_N);
      assert (!(bus.dispatch_vld && !can)) else $error("dispatch_vld while station full");
      if (!m_vld || bus.issue_ack) begin
        k = -1;
        foreach (mq[i]) if (k < 0 && !mq[i].busy[0] && !mq[i].busy[1]) k = i;
        if (k >= 0) begin
          exp_q.push_back(mk_iss(mq[k]));
          mq.delete(k);
          m_vld = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
      end
      foreach (mq[i])
        for (int o = 0; o < 2; o++)
          if (hit(mq[i].busy[o], mq[i].v[o])) begin
            mq[i].busy[o] = 1'b0;
            mq[i].v[o]    = bus.cdb.wdata;
          end
      if (bus.dispatch_vld && can) begin
        e.op    = bus.dispatch.opcode;
        e.tag   = bus.dispatch.tag;
        e.robid = bus.dispatch.robid;
        e.imm   = bus.dispatch.imm;
        for (int o = 0; o < 2; o++) begin
          e.busy[o] = bus.dispatch.oprand[o].busy;
          e.v[o]    = bus.dispatch.oprand[o].u.w;
          if (hit(e.busy[o], e.v[o])) begin
            e.busy[o] = 1'b0;
            e.v[o]    = bus.cdb.wdata;
          end
        end
        mq.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  bit     prev_vld = 1'b0;
  issue_t last_iss = '0;

  always @(posedge clk) begin : mon
    issue_t e;
    #1;
    chk("issue_vld", 128'(bus.issue_vld), 128'(m_vld));
    chk("occupancy", 128'(bus.occupancy), 128'(mq.size()));
    chk("dispatch_rdy", 128'(bus.dispatch_rdy), 128'(!rst && mq.size() < RS_N));
    if (m_rst) chk("issue_zero_after_rst", 128'(bus.issue), 128'(0));
    if (bus.issue_vld) begin
      if (!prev_vld || bus.issue_ack) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_issue: got %0h expected no issue at %0t", bus.issue, $time);
        end else begin
          e = exp_q.pop_front();
          chk("issue_payload", 128'(bus.issue), 128'(e));
        end
      end else begin
        chk("issue_stable", 128'(bus.issue), 128'(last_iss));
      end
    end
    prev_vld = bus.issue_vld;
    last_iss = bus.issue;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic dispatch_t mkd(logic [3:0] op, logic [4:0] tag,
                                    bit b0, logic [31:0] v0, bit b1, logic [31:0] v1,
                                    logic [4:0] robid, logic [31:0] imm);
    dispatch_t d;
    d.opcode           = op;
    d.tag              = tag;
    d.oprand[0].busy   = b0;
    d.oprand[0].u.w    = v0;
    d.oprand[1].busy   = b1;
    d.oprand[1].u.w    = v1;
    d.robid            = robid;
    d.imm              = imm;
    return d;
  endfunction

  task automatic disp(dispatch_t d);
    bus.dispatch_vld = 1'b1;
    bus.dispatch     = d;
    tick();
    bus.dispatch_vld = 1'b0;
  endtask

  task automatic setcdb(bit v, logic [4:0] tag, logic [31:0] data);
    bus.cdb.vld   = v;
    bus.cdb.tag   = tag;
    bus.cdb.wa    = 5'($urandom_range(0, 31));
    bus.cdb.wdata = data;
    bus.cdb.robid = 5'($urandom_range(0, 31));
  endtask

  localparam logic [3:0] OP_ADD = 4'd0;

  initial begin
    bus.dispatch_vld = 1'b0;
    bus.dispatch     = '0;
    bus.issue_ack    = 1'b1;
    setcdb(0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_rdy_low", 128'(bus.dispatch_rdy), 128'(0));
    chk("rst_vld_low", 128'(bus.issue_vld), 128'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", 128'(bus.dispatch_rdy), 128'(1));

    // T1: ready ADD dispatched, issue two cycles later
    disp(mkd(OP_ADD, 3, 0, 5, 0, 7, 9, 0));
    chk("t1_vld_n1", 128'(bus.issue_vld), 128'(0));
    chk("t1_occ_n1", 128'(bus.occupancy), 128'(1));
    tick();
    chk("t1_vld_n2", 128'(bus.issue_vld), 128'(1));
    chk("t1_rdata0", 128'(bus.issue.rdata[0]), 128'(5));
    chk("t1_rdata1", 128'(bus.issue.rdata[1]), 128'(7));
    chk("t1_op", 128'(bus.issue.op), 128'(OP_ADD));
    chk("t1_tag", 128'(bus.issue.tag), 128'(3));
    chk("t1_robid", 128'(bus.issue.robid), 128'(9));
    chk("t1_occ_n2", 128'(bus.occupancy), 128'(0));
    repeat (2) tick();

    // T2: busy on tag 12, unrelated tag 13, then 12 resolves
    disp(mkd(4'd1, 6, 1, 12, 0, 3, 2, 0));
    tick();
    setcdb(1, 13, 32'h1111_1111);
    tick();
    chk("t2_tag13_noeffect", 128'(bus.issue_vld), 128'(0));
    setcdb(1, 12, 32'hDEAD_BEEF);
    tick();
    setcdb(0, 0, 0);
    chk("t2_vld_b1", 128'(bus.issue_vld), 128'(0));
    tick();
    chk("t2_vld_b2", 128'(bus.issue_vld), 128'(1));
    chk("t2_rdata0", 128'(bus.issue.rdata[0]), 128'(32'hDEAD_BEEF));
    repeat (2) tick();

    // T3: dispatch bypass of a same-cycle broadcast
    setcdb(1, 4, 32'h55);
    disp(mkd(4'd2, 7, 1, 4, 0, 9, 3, 0));
    setcdb(0, 0, 0);
    tick();
    chk("t3_vld", 128'(bus.issue_vld), 128'(1));
    chk("t3_rdata0", 128'(bus.issue.rdata[0]), 128'(32'h55));
    repeat (2) tick();

    // T4: fill, resolve oldest (A) and youngest (D) together
    disp(mkd(4'd3, 1, 1, 20, 0, 1, 1, 0));
    disp(mkd(4'd3, 2, 1, 21, 0, 2, 2, 0));
    disp(mkd(4'd3, 3, 1, 22, 0, 3, 3, 0));
    disp(mkd(4'd3, 4, 1, 20, 0, 4, 4, 0));
    chk("t4_full_occ", 128'(bus.occupancy), 128'(RS_N));
    chk("t4_full_rdy", 128'(bus.dispatch_rdy), 128'(0));
    setcdb(1, 20, 32'hA0);
    tick();
    setcdb(0, 0, 0);
    chk("t4_rdy_while_leaving", 128'(bus.dispatch_rdy), 128'(0));
    tick();
    chk("t4_first_A", 128'(bus.issue.robid), 128'(1));
    chk("t4_rdy_after", 128'(bus.dispatch_rdy), 128'(1));
    tick();
    chk("t4_second_D", 128'(bus.issue.robid), 128'(4));
    setcdb(1, 21, 32'hB0);
    tick();
    setcdb(1, 22, 32'hC0);
    tick();
    setcdb(0, 0, 0);
    repeat (4) tick();

    // T5: output stalled, older entry resolves behind it
    bus.issue_ack = 1'b0;
    disp(mkd(4'd4, 8, 1, 7, 0, 1, 5, 32'h10));
    disp(mkd(4'd4, 9, 0, 2, 0, 3, 6, 32'h20));
    tick();
    chk("t5_q_out", 128'(bus.issue.robid), 128'(6));
    setcdb(1, 7, 32'h77);
    tick();
    setcdb(0, 0, 0);
    repeat (4) tick();
    chk("t5_hold_vld", 128'(bus.issue_vld), 128'(1));
    chk("t5_hold_robid", 128'(bus.issue.robid), 128'(6));
    bus.issue_ack = 1'b1;
    tick();
    chk("t5_p_next", 128'(bus.issue.robid), 128'(5));
    chk("t5_p_rdata0", 128'(bus.issue.rdata[0]), 128'(32'h77));
    repeat (2) tick();

    // T6: reset with entries and a pending issue
    bus.issue_ack = 1'b0;
    disp(mkd(4'd5, 10, 0, 1, 0, 1, 7, 0));
    tick();
    disp(mkd(4'd5, 11, 1, 30, 0, 1, 11, 0));
    disp(mkd(4'd5, 12, 1, 31, 0, 1, 12, 0));
    disp(mkd(4'd5, 13, 1, 29, 0, 1, 13, 0));
    chk("t6_pre_occ", 128'(bus.occupancy), 128'(3));
    chk("t6_pre_vld", 128'(bus.issue_vld), 128'(1));
    rst = 1'b1;
    tick();
    chk("t6_vld", 128'(bus.issue_vld), 128'(0));
    chk("t6_occ", 128'(bus.occupancy), 128'(0));
    rst = 1'b0;
    bus.issue_ack = 1'b1;
    repeat (3) tick();
    chk("t6_no_issue", 128'(bus.issue_vld), 128'(0));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.issue_ack = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) != 0) setcdb(1, 5'($urandom_range(0, 7)), $urandom());
      else                           setcdb(0, 0, 0);
      if (!rst && mq.size() < RS_N && $urandom_range(0, 1) == 1) begin
        bus.dispatch_vld = 1'b1;
        bus.dispatch = mkd(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 7)) : $urandom(),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 7)) : $urandom(),
                           5'($urandom_range(0, 31)), $urandom());
        // a busy operand must carry a tag in the low bits only
        if (bus.dispatch.oprand[0].busy) bus.dispatch.oprand[0].u.w = 32'($urandom_range(0, 7));
        if (bus.dispatch.oprand[1].busy) bus.dispatch.oprand[1].u.w = 32'($urandom_range(0, 7));
      end else begin
        bus.dispatch_vld = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    bus.dispatch_vld = 1'b0;

    // Drain: broadcast every tag, ack everything
    bus.issue_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      setcdb(1, 5'(c % 8), $urandom());
      tick();
    end
    setcdb(0, 0, 0);
    repeat (4) tick();
    chk("drain_empty", 128'(bus.occupancy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
